// File: rtl/mmseq_pkg.sv
// Shared types and widths for the matrix multiplier sequencer.
package mmseq_pkg;

  localparam int RES_W = 10;
  localparam int OP_W  = 4;
  localparam int IDX_W = 4;
  localparam int TMR_W = 4;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    LOAD_WAIT,
    LOAD_HI,
    LOAD_LO,
    COMP_HI,
    COMP_LO,
    OUT_SET,
    OUT_PUSH,
    DONE
  } state_t;

  // Counters stop at their terminal value instead of wrapping.
  function automatic int sat_inc(input int cnt, input int limit);
    return (cnt >= limit) ? limit : cnt + 1;
  endfunction

endpackage

// File: rtl/mmseq_pulse_timer.sv
// Loadable down-counter; zero is high once the loaded count has run out.
module mmseq_pulse_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/matrix_mult_sequencer.sv
// Drives MATRIX_MULTIPLIER through clear/load/compute/readout and streams results.
// Optional abort input is enabled by defining MMSEQ_ABORT_EN.
module matrix_mult_sequencer
  import mmseq_pkg::*;
#(
  parameter int N_OPERANDS = 18,
  parameter int N_COMPUTE  = 9,
  parameter int N_RESULTS  = 9,
  parameter int IC_HIGH    = 1,
  parameter int IC_LOW     = 1,
  parameter int OS_SETTLE  = 2
) (
  input  logic             clk,
  input  logic             mr_n,
  input  logic             start,
`ifdef MMSEQ_ABORT_EN
  input  logic             abort,
`endif
  input  logic             in_valid,
  input  logic [OP_W-1:0]  in_data,
  output logic             in_ready,
  output logic             res_valid,
  output logic [RES_W-1:0] res_data,
  output logic [IDX_W-1:0] res_idx,
  input  logic             res_ready,
  output logic             busy,
  output logic             done,
  output logic [OP_W-1:0]  mm_i,
  output logic             mm_ic,
  output logic [IDX_W-1:0] mm_os,
  output logic             mm_en,
  output logic             mm_mr,
  input  logic [RES_W-1:0] mm_matrix
);

  localparam int OPC_W  = $clog2(N_OPERANDS + 1);
  localparam int CMPC_W = $clog2(N_COMPUTE + 1);
  localparam int OSC_W  = $clog2(N_RESULTS + 1);

  localparam logic [OPC_W-1:0]  OPC_LAST = OPC_W'(N_OPERANDS);
  localparam logic [CMPC_W-1:0] CMP_LAST = CMPC_W'(N_COMPUTE);
  localparam logic [OSC_W-1:0]  OS_LAST  = OSC_W'(N_RESULTS);
  localparam logic [TMR_W-1:0]  TMR_HI   = TMR_W'(IC_HIGH - 1);
  localparam logic [TMR_W-1:0]  TMR_LO   = TMR_W'(IC_LOW - 1);
  localparam logic [TMR_W-1:0]  TMR_OS   = TMR_W'(OS_SETTLE - 1);

  state_t state_q, state_d;
  logic [OPC_W-1:0]  op_cnt_q, op_cnt_d;
  logic [CMPC_W-1:0] cmp_cnt_q, cmp_cnt_d;
  logic [OSC_W-1:0]  os_cnt_q, os_cnt_d;
  logic              tmr_load, tmr_zero, abort_hit;
  logic [TMR_W-1:0]  tmr_val;

  logic              in_ready_q, in_ready_d;
  logic              res_valid_q, res_valid_d;
  logic [RES_W-1:0]  res_data_q, res_data_d;
  logic [IDX_W-1:0]  res_idx_q, res_idx_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [OP_W-1:0]   mm_i_q, mm_i_d;
  logic              mm_ic_q, mm_ic_d;
  logic [IDX_W-1:0]  mm_os_q, mm_os_d;
  logic              mm_en_q, mm_en_d;
  logic              mm_mr_q, mm_mr_d;

  // One timer serves every timed wait; each timed state loads it on entry.
  mmseq_pulse_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (mr_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      state_q   <= IDLE;
      op_cnt_q  <= '0;
      cmp_cnt_q <= '0;
      os_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_cnt_q  <= op_cnt_d;
      cmp_cnt_q <= cmp_cnt_d;
      os_cnt_q  <= os_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_cnt_d  = op_cnt_q;
    cmp_cnt_d = cmp_cnt_q;
    os_cnt_d  = os_cnt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    abort_hit = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CLEAR;
      CLEAR: begin
        state_d   = LOAD_WAIT;
        op_cnt_d  = '0;
        cmp_cnt_d = '0;
        os_cnt_d  = '0;
      end
      LOAD_WAIT: if (in_valid && in_ready_q) begin
        state_d  = LOAD_HI;
        tmr_load = 1'b1;
        tmr_val  = TMR_HI;
      end
      LOAD_HI: if (tmr_zero) begin
        state_d  = LOAD_LO;
        tmr_load = 1'b1;
        tmr_val  = TMR_LO;
      end
      LOAD_LO: if (tmr_zero) begin
        op_cnt_d = OPC_W'(sat_inc(int'(op_cnt_q), N_OPERANDS));
        if (op_cnt_d == OPC_LAST) begin
          state_d   = COMP_HI;
          cmp_cnt_d = '0;
          tmr_load  = 1'b1;
          tmr_val   = TMR_HI;
        end else begin
          state_d = LOAD_WAIT;
        end
      end
      COMP_HI: if (tmr_zero) begin
        state_d  = COMP_LO;
        tmr_load = 1'b1;
        tmr_val  = TMR_LO;
      end
      COMP_LO: if (tmr_zero) begin
        cmp_cnt_d = CMPC_W'(sat_inc(int'(cmp_cnt_q), N_COMPUTE));
        tmr_load  = 1'b1;
        if (cmp_cnt_d == CMP_LAST) begin
          state_d  = OUT_SET;
          os_cnt_d = '0;
          tmr_val  = TMR_OS;
        end else begin
          state_d = COMP_HI;
          tmr_val = TMR_HI;
        end
      end
      OUT_SET: if (tmr_zero) state_d = OUT_PUSH;
      OUT_PUSH: if (res_ready && res_valid_q) begin
        os_cnt_d = OSC_W'(sat_inc(int'(os_cnt_q), N_RESULTS));
        if (os_cnt_d == OS_LAST) begin
          state_d = DONE;
        end else begin
          state_d  = OUT_SET;
          tmr_load = 1'b1;
          tmr_val  = TMR_OS;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef MMSEQ_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      abort_hit = 1'b1;
      tmr_load  = 1'b0;
      op_cnt_d  = '0;
      cmp_cnt_d = '0;
      os_cnt_d  = '0;
    end
`endif
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    in_ready_d  = (state_d == LOAD_WAIT);
    res_valid_d = (state_d == OUT_PUSH);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    mm_ic_d     = (state_d == LOAD_HI) || (state_d == COMP_HI);
    mm_en_d     = (state_d != IDLE) && (state_d != DONE);
    mm_mr_d     = (state_d == CLEAR) || abort_hit;
    mm_i_d      = mm_i_q;
    mm_os_d     = mm_os_q;
    res_data_d  = res_data_q;
    res_idx_d   = res_idx_q;
    if ((state_q == LOAD_WAIT) && in_valid && in_ready_q) begin
      mm_i_d = in_data;
    end
    if (state_d == OUT_SET) begin
      mm_os_d = IDX_W'(os_cnt_d);
    end else if (state_d == CLEAR) begin
      mm_os_d = '0;
    end
    if ((state_q == OUT_SET) && (state_d == OUT_PUSH)) begin
      res_data_d = mm_matrix;
      res_idx_d  = IDX_W'(os_cnt_q);
    end
  end

  always_ff @(posedge clk or negedge mr_n) begin
    if (!mr_n) begin
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mm_i_q      <= '0;
      mm_ic_q     <= 1'b0;
      mm_os_q     <= '0;
      mm_en_q     <= 1'b0;
      mm_mr_q     <= 1'b1;
    end else begin
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_idx_q   <= res_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mm_i_q      <= mm_i_d;
      mm_ic_q     <= mm_ic_d;
      mm_os_q     <= mm_os_d;
      mm_en_q     <= mm_en_d;
      mm_mr_q     <= mm_mr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mm_i      = mm_i_q;
  assign mm_ic     = mm_ic_q;
  assign mm_os     = mm_os_q;
  assign mm_en     = mm_en_q;
  assign mm_mr     = mm_mr_q;

endmodule

// File: tb/tb_matrix_mult_sequencer.sv
// Scoreboard bench for matrix_mult_sequencer with a behavioural multiplier device.
// Covers the MMSEQ_ABORT_EN abort path when that macro is defined.
module tb_matrix_mult_sequencer;

  logic       clk = 1'b0;
  logic       mr_n = 1'b0;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_data = 4'd0;
  logic       res_ready = 1'b0;
  logic       in_ready, res_valid, busy, done, mm_ic, mm_en, mm_mr;
  logic [9:0] res_data, mm_matrix;
  logic [3:0] res_idx, mm_i, mm_os;
`ifdef MMSEQ_ABORT_EN
  logic       abort = 1'b0;
  bit         ab_done = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  matrix_mult_sequencer dut (
    .clk       (clk),
    .mr_n      (mr_n),
    .start     (start),
`ifdef MMSEQ_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .mm_i      (mm_i),
    .mm_ic     (mm_ic),
    .mm_os     (mm_os),
    .mm_en     (mm_en),
    .mm_mr     (mm_mr),
    .mm_matrix (mm_matrix)
  );

  // Multiplier device: 9 A operands, 9 B operands, 9 compute strobes, then C=A*B by mm_os.
  logic [3:0] dev_a [9];
  logic [3:0] dev_b [9];
  int         dev_cnt = 0;

  always @(posedge mm_ic or posedge mm_mr) begin
    if (mm_mr) begin
      dev_cnt <= 0;
    end else if (mm_en) begin
      if (dev_cnt < 9) dev_a[dev_cnt] <= mm_i;
      else if (dev_cnt < 18) dev_b[dev_cnt - 9] <= mm_i;
      if (dev_cnt < 27) dev_cnt <= dev_cnt + 1;
    end
  end

  always_comb begin : dev_out
    int s;
    int r;
    int c;
    s = 0;
    r = int'(mm_os) / 3;
    c = int'(mm_os) % 3;
    mm_matrix = 10'h3ff;
    if (dev_cnt == 27 && mm_os < 4'd9) begin
      for (int k = 0; k < 3; k++) s = s + int'(dev_a[r*3+k]) * int'(dev_b[k*3+c]);
      mm_matrix = 10'(s);
    end
  end

  // Reference data and scoreboard.
  logic [3:0] ops [18];
  int dir_ops [18] = '{1, 4, 5, 4, 5, 6, 0, 0, 0, 10, 11, 7, 13, 14, 9, 2, 3, 4};
  int dir_res [9]  = '{72, 82, 63, 117, 132, 97, 0, 0, 0};
  int exp_idx_q [$];
  int exp_val_q [$];

  function automatic int refProduct(input int idx);
    int s;
    s = 0;
    for (int k = 0; k < 3; k++) s = s + int'(ops[(idx/3)*3+k]) * int'(ops[9+k*3+(idx%3)]);
    return s;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Monitor: pops the scoreboard on every result handshake and tracks protocol rules.
  int         cyc = 0;
  int         done_cnt = 0;
  int         ic_edges = 0;
  int         viol = 0;
  int         last_rise = -100;
  int         e_idx, e_val;
  logic       ic_prev = 1'b0, hs_prev = 1'b0, mr_prev = 1'b0, stall_prev = 1'b0;
  logic [3:0] mi_prev = 4'd0, stall_idx = 4'd0;
  logic [9:0] stall_data = 10'd0;

  always @(negedge clk) begin
    cyc++;
    if (mr_n) begin
      if (done) done_cnt++;
      if (mm_ic && !ic_prev) begin
        ic_edges++;
        if (cyc - last_rise < 2) viol++;
        last_rise = cyc;
      end
      if (in_ready && mm_ic) viol++;
      if (mr_prev && (mm_i != mi_prev) && !hs_prev) viol++;
      if (stall_prev && res_valid) begin
        checkOutput("stall_data_stable", int'(res_data), int'(stall_data));
        checkOutput("stall_idx_stable", int'(res_idx), int'(stall_idx));
      end
      if (res_valid && res_ready) begin
        if (exp_idx_q.size() == 0) begin
          checkOutput("unexpected_result", 1, 0);
        end else begin
          e_idx = exp_idx_q.pop_front();
          e_val = exp_val_q.pop_front();
          checkOutput("res_idx", int'(res_idx), e_idx);
          checkOutput("res_data", int'(res_data), e_val);
        end
      end
      stall_prev = res_valid && !res_ready;
      stall_data = res_data;
      stall_idx  = res_idx;
    end else begin
      stall_prev = 1'b0;
    end
    ic_prev = mm_ic;
    mi_prev = mm_i;
    hs_prev = in_valid && in_ready;
    mr_prev = mr_n;
  end

  // Result-side driver: 0 always ready, 1 random ready, 2 stall at index 3, 3 abort at index 4.
  int rdy_mode = 0;
  bit bp_done = 1'b0;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: res_ready = ($urandom_range(0, 3) != 0);
        2: begin
          if (res_valid && res_idx == 4'd3 && !bp_done) begin
            res_ready = 1'b0;
            bp_done   = 1'b1;
            repeat (10) @(posedge clk);
            #1;
          end
          res_ready = 1'b1;
        end
`ifdef MMSEQ_ABORT_EN
        3: begin
          if (res_valid && res_idx == 4'd4 && !ab_done) begin
            res_ready = 1'b0;
            abort     = 1'b1;
            ab_done   = 1'b1;
            @(posedge clk);
            #1;
            abort = 1'b0;
            exp_idx_q.delete();
            exp_val_q.delete();
            @(negedge clk);
            checkOutput("abort_res_valid", int'(res_valid), 0);
            checkOutput("abort_mm_mr", int'(mm_mr), 1);
            checkOutput("abort_busy", int'(busy), 0);
            @(negedge clk);
            checkOutput("abort_mm_mr_drop", int'(mm_mr), 0);
          end
          res_ready = 1'b1;
        end
`endif
        default: res_ready = 1'b1;
      endcase
    end
  end

  task automatic pulseStart();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic feedOperand(input logic [3:0] v, input int gap_max);
    int g;
    bit got;
    g   = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    got = 1'b0;
    in_valid = 1'b0;
    repeat (g) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data  = v;
    for (int c = 0; c < 100 && !got; c++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!got) checkOutput("operand_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic checkResetValues();
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_res_valid", int'(res_valid), 0);
    checkOutput("rst_res_data", int'(res_data), 0);
    checkOutput("rst_res_idx", int'(res_idx), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_mm_i", int'(mm_i), 0);
    checkOutput("rst_mm_ic", int'(mm_ic), 0);
    checkOutput("rst_mm_os", int'(mm_os), 0);
    checkOutput("rst_mm_en", int'(mm_en), 0);
    checkOutput("rst_mm_mr", int'(mm_mr), 1);
  endtask

  // One complete job; expect_done=0 means the job is expected to be aborted.
  task automatic applyStimulus(input bit directed, input int gap_max, input bit stress,
                               input bit expect_done);
    bit finished;
    done_cnt = 0;
    ic_edges = 0;
    viol     = 0;
    bp_done  = 1'b0;
    finished = 1'b0;
    for (int i = 0; i < 18; i++) ops[i] = directed ? 4'(dir_ops[i]) : 4'($urandom_range(0, 15));
    pulseStart();
    for (int i = 0; i < 18; i++) feedOperand(ops[i], gap_max);
    for (int k = 0; k < 9; k++) begin
      exp_idx_q.push_back(k);
      exp_val_q.push_back(directed ? dir_res[k] : refProduct(k));
    end
    if (stress) begin
      repeat (12) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'($urandom_range(0, 15));
        @(posedge clk);
        #1;
      end
      start    = 1'b0;
      in_valid = 1'b0;
    end
    for (int c = 0; c < 3000 && !finished; c++) begin
      @(negedge clk);
      if (expect_done ? done : !busy) finished = 1'b1;
    end
    checkOutput("job_finished", int'(finished), 1);
    repeat (3) @(negedge clk);
    checkOutput("done_pulses", done_cnt, int'(expect_done));
    if (expect_done) begin
      checkOutput("ic_edges", ic_edges, 27);
      checkOutput("results_left", exp_idx_q.size(), 0);
    end
    checkOutput("busy_after_job", int'(busy), 0);
    checkOutput("mm_mr_after_job", int'(mm_mr), 0);
    checkOutput("protocol_violations", viol, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [3:0] r;
    repeat (3) @(posedge clk);
    #1 checkResetValues();
    mr_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_in_ready", int'(in_ready), 0);
    checkOutput("idle_mm_mr_held", int'(mm_mr), 1);
    @(negedge clk);
    checkOutput("idle_mm_mr_drop", int'(mm_mr), 0);

    $display("[TB] directed job, continuous operands");
    rdy_mode = 0;
    applyStimulus(1'b1, 0, 1'b0, 1'b1);

    $display("[TB] directed job, gapped operands, random ready");
    rdy_mode = 1;
    applyStimulus(1'b1, 5, 1'b0, 1'b1);

    $display("[TB] random job, backpressure at index 3");
    rdy_mode = 2;
    applyStimulus(1'b0, 2, 1'b0, 1'b1);

    $display("[TB] random job, start and in_valid while busy");
    rdy_mode = 1;
    applyStimulus(1'b0, 0, 1'b1, 1'b1);

    $display("[TB] reset in the middle of loading");
    rdy_mode = 0;
    pulseStart();
    for (int i = 0; i < 7; i++) begin
      r = 4'($urandom_range(0, 15));
      feedOperand(r, 1);
    end
    repeat (2) @(posedge clk);
    #1 mr_n = 1'b0;
    #2 checkResetValues();
    repeat (3) @(posedge clk);
    #1 mr_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_in_ready", int'(in_ready), 0);
    checkOutput("post_reset_busy", int'(busy), 0);
    checkOutput("post_reset_mm_mr_held", int'(mm_mr), 1);
    @(negedge clk);
    checkOutput("post_reset_mm_mr_drop", int'(mm_mr), 0);
    checkOutput("post_reset_no_results", exp_idx_q.size(), 0);

    $display("[TB] random job after reset");
    applyStimulus(1'b0, 3, 1'b0, 1'b1);

`ifdef MMSEQ_ABORT_EN
    $display("[TB] abort at result 4");
    rdy_mode = 3;
    ab_done  = 1'b0;
    applyStimulus(1'b0, 0, 1'b0, 1'b0);
    checkOutput("abort_taken", int'(ab_done), 1);
    rdy_mode = 0;
    applyStimulus(1'b1, 0, 1'b0, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
